// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (ADD/SUB/XOR/RED/SLL/SRA/ROR/PADDSB) holding the {Z,V,N} flag register; result valid 2 cycles after accept.
// Valid/ready on both sides: holds S1 and the output while out_ready is low, accepting while S1 is empty or draining.
module alu_pipe #(
   parameter int WIDTH = 16,
   parameter int LANE  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             is_alu,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags,
   output logic             flags_busy
);
   localparam int H  = WIDTH / 2;
   localparam int SW = $clog2(WIDTH);
   localparam int NL = WIDTH / LANE;

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_XOR = 3'b010, OP_RED = 3'b011,
                          OP_SLL = 3'b100, OP_SRA = 3'b101, OP_ROR = 3'b110, OP_PADD = 3'b111;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic             s1_valid, s1_is_alu, s1_flagop;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic             adv2, accept, out_flagop;
   logic [2:0]       out_zvn, out_mask;

   assign adv2       = ~out_valid | out_ready;
   assign in_ready   = ~flush & (~s1_valid | adv2);
   assign accept     = in_valid & in_ready;
   assign s1_flagop  = s1_is_alu & (s1_op != OP_RED) & (s1_op != OP_PADD);
   assign flags_busy = (s1_valid & s1_flagop) | (out_valid & out_flagop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= 3'b000;
         s1_is_alu <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
      end else begin
         if (flush)
            s1_valid <= 1'b0;
         else if (accept)
            s1_valid <= 1'b1;
         else if (adv2)
            s1_valid <= 1'b0;
         if (accept) begin
            s1_op     <= op;
            s1_is_alu <= is_alu;
            s1_a      <= a;
            s1_b      <= b;
         end
      end
   end

   // S2 combinational datapath
   logic             sub, ov;
   logic [WIDTH-1:0] b_x, raw, red, padd, nxt_res;
   logic [H:0]       hs, ls;
   logic [H+1:0]     t;
   logic [SW-1:0]    amt;
   logic [LANE-1:0]  la, lb, lsum;
   logic [2:0]       nxt_zvn, nxt_mask;

   always_comb begin
      sub  = (s1_op == OP_SUB);
      b_x  = s1_b ^ {WIDTH{sub}};
      raw  = s1_a + b_x + {{(WIDTH-1){1'b0}}, sub};
      ov   = (s1_a[WIDTH-1] == b_x[WIDTH-1]) & (raw[WIDTH-1] != s1_a[WIDTH-1]);
      hs   = {1'b0, s1_a[WIDTH-1:H]} + {1'b0, s1_b[WIDTH-1:H]};
      ls   = {1'b0, s1_a[H-1:0]} + {1'b0, s1_b[H-1:0]};
      t    = {1'b0, hs} + {1'b0, ls};
      red  = {{(WIDTH-H-2){t[H+1]}}, t};
      amt  = s1_b[SW-1:0];
      padd = '0;
      la   = '0;
      lb   = '0;
      lsum = '0;
      for (int i = 0; i < NL; i++) begin
         la   = s1_a[i*LANE +: LANE];
         lb   = s1_b[i*LANE +: LANE];
         lsum = la + lb;
         if ((la[LANE-1] == lb[LANE-1]) && (lsum[LANE-1] != la[LANE-1]))
            lsum = la[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
         padd[i*LANE +: LANE] = lsum;
      end

      nxt_res  = '0;
      nxt_mask = 3'b100;
      case (s1_op)
         OP_ADD, OP_SUB: begin
            // positive overflow wraps to a negative raw sum, hence N selects the max clamp
            nxt_res  = ov ? (raw[WIDTH-1] ? SMAX : SMIN) : raw;
            nxt_mask = 3'b111;
         end
         OP_XOR:  nxt_res = s1_a ^ s1_b;
         OP_RED: begin
            nxt_res  = red;
            nxt_mask = 3'b000;
         end
         OP_SLL:  nxt_res = s1_a << amt;
         OP_SRA:  nxt_res = WIDTH'($signed(s1_a) >>> amt);
         OP_ROR:  nxt_res = (s1_a >> amt) | (s1_a << (WIDTH - int'(amt)));
         default: begin
            nxt_res  = padd;
            nxt_mask = 3'b000;
         end
      endcase

      if ((s1_op == OP_ADD) || (s1_op == OP_SUB))
         nxt_zvn = {(raw == '0), ov, raw[WIDTH-1]};
      else
         nxt_zvn = {(nxt_res == '0), 2'b00};
      nxt_mask = nxt_mask & {3{s1_is_alu}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         result     <= '0;
         out_zvn    <= 3'b000;
         out_mask   <= 3'b000;
         out_flagop <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result     <= nxt_res;
            out_zvn    <= nxt_zvn;
            out_mask   <= nxt_mask;
            out_flagop <= s1_flagop;
         end
      end
   end

   // Flags commit only when the consumer takes the result, so they follow program order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flags <= 3'b000;
      else if (out_valid & out_ready & ~flush)
         flags <= (flags & ~out_mask) | (out_zvn & out_mask);
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases from the operation rules plus randomized traffic
// checked against an arithmetic reference model and an in-order expectation queue.
module tb_alu_pipe;
   localparam int W = 16;
   localparam int L = 4;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b010, RED = 3'b011,
                          SLL = 3'b100, SRA = 3'b101, ROR = 3'b110, PADD = 3'b111;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, in_ready, is_alu, out_valid, out_ready, flags_busy;
   logic [2:0]   op, flags;
   logic [W-1:0] a, b, result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(W), .LANE(L)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .is_alu(is_alu), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .flags_busy(flags_busy)
   );

   typedef struct {
      logic [15:0] res;
      logic [2:0]  zvn;
      logic [2:0]  mask;
      logic        fop;
      int          acc;
   } exp_t;

   // Reference model: signed integer arithmetic with explicit clamping.
   function automatic void ref_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                  input logic alu, output logic [15:0] r, output logic [2:0] zvn,
                                  output logic [2:0] mask);
      int sx, sy, s, t, n, la, lb;
      logic [15:0] rw;
      logic v;
      sx = int'($signed(x));
      sy = int'($signed(y));
      n  = int'(y[3:0]);
      r  = 16'h0000;
      zvn = 3'b000;
      mask = 3'b100;
      case (o)
         ADD, SUB: begin
            s  = (o == ADD) ? sx + sy : sx - sy;
            rw = s[15:0];
            v  = (s > 32767) || (s < -32768);
            r  = v ? ((s > 0) ? 16'h7FFF : 16'h8000) : rw;
            mask = 3'b111;
         end
         XOR: r = x ^ y;
         RED: begin
            t = int'(x[15:8]) + int'(y[15:8]) + int'(x[7:0]) + int'(y[7:0]);
            if (t >= 512) t = t - 1024;
            r = t[15:0];
            mask = 3'b000;
         end
         SLL: begin
            t = int'(x) << n;
            r = t[15:0];
         end
         SRA: begin
            t = sx >>> n;
            r = t[15:0];
         end
         ROR: begin
            t = (int'(x) >> n) | (int'(x) << (16 - n));
            r = t[15:0];
         end
         default: begin
            for (int l = 0; l < 4; l++) begin
               la = int'(x[4*l +: 4]);
               lb = int'(y[4*l +: 4]);
               if (la > 7) la = la - 16;
               if (lb > 7) lb = lb - 16;
               s = la + lb;
               if (s > 7) s = 7;
               if (s < -8) s = -8;
               r[4*l +: 4] = s[3:0];
            end
            mask = 3'b000;
         end
      endcase
      if (o == ADD || o == SUB) zvn = {rw == 16'h0, v, rw[15]};
      else                      zvn = {r == 16'h0, 2'b00};
      if (!alu) mask = 3'b000;
   endfunction

   task automatic exec(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic alu, output logic [15:0] r, output logic [2:0] f);
      bit ok;
      r = 16'h0;
      @(posedge clk); #1;
      in_valid = 1'b1; op = o; a = x; b = y; is_alu = alu; out_ready = 1'b1; flush = 1'b0;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL exec_accept op %0d got in_ready 0 exp 1", o); end
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; r = result; end
      end
      @(posedge clk); #1;
      f = flags;
      checks++;
      if (!ok) begin errors++; $display("FAIL exec_result op %0d got out_valid 0 exp 1", o); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'b000; is_alu = 1'b0; a = '0; b = '0;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", flags); end
      checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", flags_busy); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_arith();
      logic [15:0] r; logic [2:0] f;
      exec(ADD, 16'h7FFF, 16'h0001, 1'b1, r, f);
      checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL add_sat result got %h exp 7fff", r); end
      checks++; if (f !== 3'b011) begin errors++; $display("FAIL add_sat flags got %b exp 011", f); end
      exec(SUB, 16'h1234, 16'h1234, 1'b1, r, f);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL sub_zero result got %h exp 0000", r); end
      checks++; if (f !== 3'b100) begin errors++; $display("FAIL sub_zero flags got %b exp 100", f); end
      exec(XOR, 16'h00F0, 16'h000F, 1'b1, r, f);
      checks++; if (r !== 16'h00FF) begin errors++; $display("FAIL xor result got %h exp 00ff", r); end
      checks++; if (f !== 3'b000) begin errors++; $display("FAIL xor flags got %b exp 000", f); end
   endtask

   task automatic test_lanes();
      logic [15:0] r; logic [2:0] f;
      exec(ADD, 16'h7FFF, 16'h0001, 1'b1, r, f);
      exec(PADD, 16'h7813, 16'h18F2, 1'b1, r, f);
      checks++; if (r !== 16'h7805) begin errors++; $display("FAIL paddsb result got %h exp 7805", r); end
      checks++; if (f !== 3'b011) begin errors++; $display("FAIL paddsb flags got %b exp 011", f); end
      exec(RED, 16'hFF01, 16'hFF01, 1'b1, r, f);
      checks++; if (r !== 16'hFE00) begin errors++; $display("FAIL red result got %h exp fe00", r); end
      checks++; if (f !== 3'b011) begin errors++; $display("FAIL red flags got %b exp 011", f); end
      exec(SUB, 16'h0055, 16'h0055, 1'b0, r, f);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL noalu result got %h exp 0000", r); end
      checks++; if (f !== 3'b011) begin errors++; $display("FAIL noalu flags got %b exp 011", f); end
   endtask

   task automatic test_shifts();
      logic [15:0] r; logic [2:0] f;
      exec(SRA, 16'h8000, 16'h0004, 1'b1, r, f);
      checks++; if (r !== 16'hF800) begin errors++; $display("FAIL sra result got %h exp f800", r); end
      exec(ROR, 16'h0001, 16'h0001, 1'b1, r, f);
      checks++; if (r !== 16'h8000) begin errors++; $display("FAIL ror result got %h exp 8000", r); end
      exec(SLL, 16'h0001, 16'h000F, 1'b1, r, f);
      checks++; if (r !== 16'h8000) begin errors++; $display("FAIL sll result got %h exp 8000", r); end
      checks++; if (f !== 3'b011) begin errors++; $display("FAIL sll flags got %b exp 011", f); end
      exec(ROR, 16'hABCD, 16'hFFF0, 1'b1, r, f);
      checks++; if (r !== 16'hABCD) begin errors++; $display("FAIL ror0 result got %h exp abcd", r); end
      exec(SLL, 16'h0000, 16'h0003, 1'b1, r, f);
      checks++; if (f !== 3'b111) begin errors++; $display("FAIL sll_zero flags got %b exp 111", f); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] xs[3], ys[3], er[3];
      logic [2:0]  ez[3], em;
      int idx;
      bit acc;
      xs = '{16'h0001, 16'h0002, 16'h8000};
      ys = '{16'h0001, 16'h0002, 16'h8000};
      for (int i = 0; i < 3; i++) ref_op(ADD, xs[i], ys[i], 1'b1, er[i], ez[i], em);
      idx = 0;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; is_alu = 1'b1; op = ADD; a = xs[0]; b = ys[0];
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) begin idx++; a = xs[idx % 3]; b = ys[idx % 3]; end
      end
      @(negedge clk);
      checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      checks++; if (result !== er[0]) begin errors++; $display("FAIL bp_hold got %h exp %h", result, er[0]); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid %0d got %b exp 1", k, out_valid); end
         checks++; if (result !== er[k]) begin errors++; $display("FAIL drain_result %0d got %h exp %h", k, result, er[k]); end
         checks++; if (flags_busy !== 1'b1) begin errors++; $display("FAIL drain_busy %0d got %b exp 1", k, flags_busy); end
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) begin idx++; in_valid = 1'b0; end
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
      checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL drain_busy_end got %b exp 0", flags_busy); end
      checks++; if (flags !== ez[2]) begin errors++; $display("FAIL drain_flags got %b exp %b", flags, ez[2]); end
   endtask

   task automatic test_flush();
      logic [2:0] saved;
      int n;
      bit acc;
      saved = flags;
      n = 0;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; is_alu = 1'b1; op = SUB; a = 16'h0005; b = 16'h0005;
      for (int c = 0; c < 6 && n < 2; c++) begin
         @(negedge clk); acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) n++;
      end
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
      checks++; if (flags !== saved) begin errors++; $display("FAIL flush_flags got %b exp %b", flags, saved); end
      checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", flags_busy); end
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got %b exp 0", out_valid); end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; is_alu = 1'b1; op = ADD; a = 16'h1111; b = 16'h2222;
      repeat (3) @(posedge clk);
      #2;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b exp 0", out_valid); end
      checks++; if (result !== 16'h0) begin errors++; $display("FAIL arst_result got %h exp 0000", result); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL arst_flags got %b exp 000", flags); end
      checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", flags_busy); end
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      logic [2:0] mflags;
      bit exp_rdy, exp_vld, busy;
      int cyc;
      mflags = 3'b000;
      cyc = 0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         op        = 3'($urandom_range(0, 7));
         is_alu    = 1'($urandom_range(0, 1));
         a         = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
         b         = 16'($urandom);
         @(negedge clk);
         exp_rdy = !flush && (q.size() < 2 || out_ready);
         exp_vld = (q.size() > 0) && (cyc - q[0].acc >= 1);
         busy = 0;
         foreach (q[i]) busy |= q[i].fop;
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", c, in_ready, exp_rdy); end
         checks++; if (out_valid !== exp_vld) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b exp %b", c, out_valid, exp_vld); end
         checks++; if (flags !== mflags) begin errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", c, flags, mflags); end
         checks++; if (flags_busy !== busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, flags_busy, busy); end
         if (exp_vld) begin
            checks++; if (result !== q[0].res) begin errors++; $display("FAIL rnd_result cyc %0d got %h exp %h", c, result, q[0].res); end
         end
         cyc++;
         if (flush) begin
            q.delete();
         end else begin
            if (exp_vld && out_ready) begin
               e = q.pop_front();
               mflags = (mflags & ~e.mask) | (e.zvn & e.mask);
            end
            if (in_valid && exp_rdy) begin
               ref_op(op, a, b, is_alu, e.res, e.zvn, e.mask);
               e.fop = is_alu && op != RED && op != PADD;
               e.acc = cyc;
               q.push_back(e);
            end
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_lanes();
      test_shifts();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
endmodule
